// File: rtl/ahb_interface.sv
//============================================================================
// Module      : ahb_interface
// Description : AHB-Lite slave with an 8-bit byte-addressed register file
//               (payload, data_size, read-only err_status). The optional
//               two-cycle ERROR response is enabled by AHB_IF_ERROR_RESP_EN.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module ahb_interface #(
    parameter int ERR_STATUS_ADDRESS = 1,
    parameter int PAYLOAD_ADDRESS    = 2,
    parameter int DATA_SIZE_ADDRESS  = 4,
    parameter int ERR_STATUS_HSIZE   = 0,
    parameter int PAYLOAD_HSIZE      = 1,
    parameter int DATA_SIZE_HSIZE    = 0
) (
    input  logic        hclk,
    input  logic        hreset_n,
    input  logic        hsel_x,
    input  logic        hready,
    input  logic        hwrite,
    input  logic [2:0]  haddr,
    input  logic [1:0]  htrans,
    input  logic [2:0]  hsize,
    input  logic [7:0]  hwdata,
    input  logic [1:0]  err_status,
    output logic [15:0] payload,
    output logic [4:0]  data_size,
    output logic [7:0]  hrdata,
    output logic        hready_out,
    output logic        hresp
);

    localparam logic [2:0] c_err_addr    = 3'(ERR_STATUS_ADDRESS);
    localparam logic [2:0] c_pay_lo_addr = 3'(PAYLOAD_ADDRESS);
    localparam logic [2:0] c_pay_hi_addr = 3'(PAYLOAD_ADDRESS + 1);
    localparam logic [2:0] c_ds_addr     = 3'(DATA_SIZE_ADDRESS);

    // Widest nominal register size: any transfer up to this size is legal anywhere.
    localparam int         c_max_hsize_a = (ERR_STATUS_HSIZE > PAYLOAD_HSIZE) ?
                                           ERR_STATUS_HSIZE : PAYLOAD_HSIZE;
    localparam int         c_max_hsize_b = (c_max_hsize_a > DATA_SIZE_HSIZE) ?
                                           c_max_hsize_a : DATA_SIZE_HSIZE;
    localparam logic [2:0] c_max_hsize   = 3'(c_max_hsize_b);

    localparam logic [1:0] c_htrans_nonseq = 2'b10;
    localparam logic [1:0] c_htrans_seq    = 2'b11;

    logic        r_dp_valid;
    logic        r_dp_write;
    logic [2:0]  r_dp_addr;
    logic [2:0]  r_dp_size;
    logic [15:0] r_payload;
    logic [4:0]  r_data_size;

    logic        w_mapped;
    logic        w_illegal;
    logic        w_stall;
    logic        w_bus_ready;
    logic        w_accept;
    logic        w_complete;
    logic        w_wr_ok;
    logic [7:0]  w_rdata;

    assign w_mapped = (r_dp_addr == c_err_addr)    || (r_dp_addr == c_pay_lo_addr) ||
                      (r_dp_addr == c_pay_hi_addr) || (r_dp_addr == c_ds_addr);

    assign w_illegal = !w_mapped || (r_dp_size > c_max_hsize) ||
                       (r_dp_write && (r_dp_addr == c_err_addr));

`ifdef AHB_IF_ERROR_RESP_EN
    localparam logic [1:0] c_st_okay = 2'd0;
    localparam logic [1:0] c_st_err1 = 2'd1;
    localparam logic [1:0] c_st_err2 = 2'd2;

    logic [1:0] r_state;
    logic       r_hready_out;
    logic       r_hresp;

    // First ERROR cycle holds hready_out low, so the bus cannot advance then.
    assign w_stall = (r_state == c_st_err1);

    always_ff @(posedge hclk) begin
        if (hreset_n) begin
            r_state      <= c_st_okay;
            r_hready_out <= 1'b1;
            r_hresp      <= 1'b0;
        end else begin
            case (r_state)
                c_st_err1: begin
                    r_state      <= c_st_err2;
                    r_hready_out <= 1'b1;
                    r_hresp      <= 1'b1;
                end
                default: begin
                    if (w_complete && w_illegal) begin
                        r_state      <= c_st_err1;
                        r_hready_out <= 1'b0;
                        r_hresp      <= 1'b1;
                    end else begin
                        r_state      <= c_st_okay;
                        r_hready_out <= 1'b1;
                        r_hresp      <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign hready_out = r_hready_out;
    assign hresp      = r_hresp;
`else
    assign w_stall    = 1'b0;
    assign hready_out = 1'b1;
    assign hresp      = 1'b0;
`endif

    assign w_bus_ready = hready && !w_stall;
    assign w_accept    = hsel_x && w_bus_ready &&
                         ((htrans == c_htrans_nonseq) || (htrans == c_htrans_seq));
    assign w_complete  = r_dp_valid && w_bus_ready;
    assign w_wr_ok     = w_complete && r_dp_write && !w_illegal;

    always_ff @(posedge hclk) begin
        if (hreset_n) begin
            r_dp_valid  <= 1'b0;
            r_dp_write  <= 1'b0;
            r_dp_addr   <= 3'd0;
            r_dp_size   <= 3'd0;
            r_payload   <= 16'd0;
            r_data_size <= 5'd0;
        end else begin
            // A pending data phase retires and a new one may load on the same edge.
            if (w_bus_ready) begin
                r_dp_valid <= w_accept;
                if (w_accept) begin
                    r_dp_write <= hwrite;
                    r_dp_addr  <= haddr;
                    r_dp_size  <= hsize;
                end
            end
            if (w_wr_ok) begin
                if (r_dp_addr == c_ds_addr)
                    r_data_size <= hwdata[4:0];
                else if (r_dp_addr == c_pay_lo_addr)
                    r_payload[7:0] <= hwdata;
                else if (r_dp_addr == c_pay_hi_addr)
                    r_payload[15:8] <= hwdata;
            end
        end
    end

    always_comb begin
        w_rdata = 8'd0;
        if (r_dp_valid && !r_dp_write && !w_illegal) begin
            case (r_dp_addr)
                c_err_addr:    w_rdata = {6'd0, err_status};
                c_pay_lo_addr: w_rdata = r_payload[7:0];
                c_pay_hi_addr: w_rdata = r_payload[15:8];
                c_ds_addr:     w_rdata = {3'd0, r_data_size};
                default:       w_rdata = 8'd0;
            endcase
        end
    end

    assign hrdata    = w_rdata;
    assign payload   = r_payload;
    assign data_size = r_data_size;

endmodule

`default_nettype wire

// File: tb/tb_ahb_interface.sv
//============================================================================
// Module      : tb_ahb_interface
// Description : Self-checking bench for ahb_interface: vector table plus
//               hand-written wait-state, pipelining, error and reset sequences.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module tb_ahb_interface;

    logic        hclk = 1'b0;
    logic        hreset_n;
    logic        hsel_x;
    logic        hready;
    logic        hwrite;
    logic [2:0]  haddr;
    logic [1:0]  htrans;
    logic [2:0]  hsize;
    logic [7:0]  hwdata;
    logic [1:0]  err_status;
    logic [15:0] payload;
    logic [4:0]  data_size;
    logic [7:0]  hrdata;
    logic        hready_out;
    logic        hresp;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] exp_q[$];

    typedef struct {
        logic        wr;
        logic        sel;
        logic [1:0]  trans;
        logic [2:0]  addr;
        logic [2:0]  size;
        logic [7:0]  wdata;
        logic [1:0]  err;
        logic [7:0]  exp_rd;
        logic        exp_ill;
        logic [15:0] exp_pay;
        logic [4:0]  exp_ds;
    } vec_t;

    vec_t vecs[20];

    ahb_interface dut (
        .hclk       (hclk),
        .hreset_n   (hreset_n),
        .hsel_x     (hsel_x),
        .hready     (hready),
        .hwrite     (hwrite),
        .haddr      (haddr),
        .htrans     (htrans),
        .hsize      (hsize),
        .hwdata     (hwdata),
        .err_status (err_status),
        .payload    (payload),
        .data_size  (data_size),
        .hrdata     (hrdata),
        .hready_out (hready_out),
        .hresp      (hresp)
    );

    always #5 hclk = ~hclk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1);
    end

    function automatic vec_t mk(input logic wr, input logic sel, input logic [1:0] trans,
                                input logic [2:0] addr, input logic [2:0] size,
                                input logic [7:0] wdata, input logic [1:0] err,
                                input logic [7:0] exp_rd, input logic exp_ill,
                                input logic [15:0] exp_pay, input logic [4:0] exp_ds);
        vec_t v;
        v.wr = wr; v.sel = sel; v.trans = trans; v.addr = addr; v.size = size;
        v.wdata = wdata; v.err = err; v.exp_rd = exp_rd; v.exp_ill = exp_ill;
        v.exp_pay = exp_pay; v.exp_ds = exp_ds;
        return v;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_rd(input string name);
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s: got empty scoreboard expected an entry", name);
        end else begin
            chk(name, {8'd0, hrdata}, {8'd0, exp_q.pop_front()});
        end
    endtask

    task automatic chk_resp(input string name, input logic rdy, input logic rsp);
        chk({name, "_hready_out"}, {15'd0, hready_out}, {15'd0, rdy});
        chk({name, "_hresp"},      {15'd0, hresp},      {15'd0, rsp});
    endtask

    // Inputs are driven and outputs sampled on the falling edge.
    task automatic step();
        @(posedge hclk);
        @(negedge hclk);
    endtask

    task automatic bus_idle();
        hsel_x = 1'b0; htrans = 2'b00; hwrite = 1'b0; haddr = 3'd0; hsize = 3'd0;
    endtask

    task automatic addr_phase(input logic wr, input logic [2:0] addr, input logic [2:0] size,
                              input logic [1:0] trans);
        hsel_x = 1'b1; htrans = trans; hwrite = wr; haddr = addr; hsize = size;
    endtask

    task automatic err_tail(input string name);
`ifdef AHB_IF_ERROR_RESP_EN
        chk_resp({name, "_err1"}, 1'b0, 1'b1);
        step();
        chk_resp({name, "_err2"}, 1'b1, 1'b1);
        step();
        chk_resp({name, "_okay"}, 1'b1, 1'b0);
`else
        chk_resp({name, "_noerr"}, 1'b1, 1'b0);
`endif
    endtask

    initial begin
        vecs[0]  = mk(1, 1, 2'd2, 3'd4, 3'd0, 8'hEC, 2'd0, 8'h00, 0, 16'h0000, 5'h0C);
        vecs[1]  = mk(0, 1, 2'd2, 3'd4, 3'd0, 8'h00, 2'd0, 8'h0C, 0, 16'h0000, 5'h0C);
        vecs[2]  = mk(1, 1, 2'd3, 3'd2, 3'd1, 8'h29, 2'd0, 8'h00, 0, 16'h0029, 5'h0C);
        vecs[3]  = mk(1, 1, 2'd2, 3'd3, 3'd0, 8'h0D, 2'd0, 8'h00, 0, 16'h0D29, 5'h0C);
        vecs[4]  = mk(0, 1, 2'd2, 3'd2, 3'd1, 8'h00, 2'd0, 8'h29, 0, 16'h0D29, 5'h0C);
        vecs[5]  = mk(0, 1, 2'd2, 3'd3, 3'd0, 8'h00, 2'd0, 8'h0D, 0, 16'h0D29, 5'h0C);
        vecs[6]  = mk(0, 1, 2'd2, 3'd1, 3'd0, 8'h00, 2'd2, 8'h02, 0, 16'h0D29, 5'h0C);
        vecs[7]  = mk(0, 1, 2'd2, 3'd1, 3'd1, 8'h00, 2'd1, 8'h01, 0, 16'h0D29, 5'h0C);
        vecs[8]  = mk(1, 1, 2'd2, 3'd1, 3'd0, 8'hFF, 2'd0, 8'h00, 1, 16'h0D29, 5'h0C);
        vecs[9]  = mk(1, 1, 2'd2, 3'd6, 3'd0, 8'h55, 2'd0, 8'h00, 1, 16'h0D29, 5'h0C);
        vecs[10] = mk(1, 1, 2'd2, 3'd4, 3'd2, 8'h1F, 2'd0, 8'h00, 1, 16'h0D29, 5'h0C);
        vecs[11] = mk(0, 1, 2'd2, 3'd0, 3'd0, 8'h00, 2'd3, 8'h00, 1, 16'h0D29, 5'h0C);
        vecs[12] = mk(0, 1, 2'd2, 3'd4, 3'd2, 8'h00, 2'd0, 8'h00, 1, 16'h0D29, 5'h0C);
        vecs[13] = mk(1, 1, 2'd2, 3'd4, 3'd1, 8'h1F, 2'd0, 8'h00, 0, 16'h0D29, 5'h1F);
        vecs[14] = mk(0, 1, 2'd2, 3'd5, 3'd0, 8'h00, 2'd0, 8'h00, 1, 16'h0D29, 5'h1F);
        vecs[15] = mk(1, 0, 2'd2, 3'd4, 3'd0, 8'h05, 2'd0, 8'h00, 0, 16'h0D29, 5'h1F);
        vecs[16] = mk(1, 1, 2'd1, 3'd4, 3'd0, 8'h06, 2'd0, 8'h00, 0, 16'h0D29, 5'h1F);
        vecs[17] = mk(0, 1, 2'd0, 3'd4, 3'd0, 8'h00, 2'd0, 8'h00, 0, 16'h0D29, 5'h1F);
        vecs[18] = mk(1, 1, 2'd2, 3'd7, 3'd0, 8'hAA, 2'd0, 8'h00, 1, 16'h0D29, 5'h1F);
        vecs[19] = mk(0, 1, 2'd2, 3'd4, 3'd0, 8'h00, 2'd0, 8'h1F, 0, 16'h0D29, 5'h1F);

        // Reset
        bus_idle();
        hready = 1'b1; hwdata = 8'h00; err_status = 2'b00; hreset_n = 1'b1;
        @(negedge hclk);
        step();
        step();
        hreset_n = 1'b0;
        chk("rst_payload", payload, 16'h0000);
        chk("rst_data_size", {11'd0, data_size}, 16'h0000);
        chk("rst_hrdata", {8'd0, hrdata}, 16'h0000);
        chk_resp("rst", 1'b1, 1'b0);

        // Write 12 to data_size with one address wait and two data wait cycles
        addr_phase(1'b1, 3'd4, 3'd0, 2'd2);
        hready = 1'b0;
        step();
        chk_resp("aw", 1'b1, 1'b0);
        hready = 1'b1;
        step();
        bus_idle();
        hwdata = 8'h0C;
        hready = 1'b0;
        step();
        chk("dwait1_ds", {11'd0, data_size}, 16'h0000);
        chk_resp("dwait1", 1'b1, 1'b0);
        step();
        chk("dwait2_ds", {11'd0, data_size}, 16'h0000);
        hready = 1'b1;
        step();
        chk("dwait_done_ds", {11'd0, data_size}, 16'h000C);
        chk_resp("dwait_done", 1'b1, 1'b0);

        // Table of single transfers, each followed by an idle cycle
        for (int i = 0; i < 20; i++) begin
            addr_phase(vecs[i].wr, vecs[i].addr, vecs[i].size, vecs[i].trans);
            hsel_x = vecs[i].sel;
            err_status = vecs[i].err;
            if (!vecs[i].wr) exp_q.push_back(vecs[i].exp_rd);
            step();
            bus_idle();
            hwdata = vecs[i].wdata;
            if (!vecs[i].wr) chk_rd($sformatf("v%0d_rdata", i));
            chk_resp($sformatf("v%0d_dp", i), 1'b1, 1'b0);
            step();
            chk($sformatf("v%0d_payload", i), payload, vecs[i].exp_pay);
            chk($sformatf("v%0d_data_size", i), {11'd0, data_size}, {11'd0, vecs[i].exp_ds});
            chk($sformatf("v%0d_rd_idle", i), {8'd0, hrdata}, 16'h0000);
            if (vecs[i].exp_ill) err_tail($sformatf("v%0d", i));
            else chk_resp($sformatf("v%0d_after", i), 1'b1, 1'b0);
        end
        err_status = 2'b00;

`ifdef AHB_IF_ERROR_RESP_EN
        // A new address phase offered during the first ERROR cycle is ignored
        addr_phase(1'b1, 3'd6, 3'd0, 2'd2);
        step();
        bus_idle();
        hwdata = 8'h77;
        step();
        chk_resp("blk_err1", 1'b0, 1'b1);
        addr_phase(1'b1, 3'd4, 3'd0, 2'd2);
        step();
        chk_resp("blk_err2", 1'b1, 1'b1);
        bus_idle();
        hwdata = 8'h03;
        step();
        chk_resp("blk_okay", 1'b1, 1'b0);
        chk("blk_data_size", {11'd0, data_size}, 16'h001F);
`endif

        // Back-to-back pipelined writes then reads of the payload bytes
        addr_phase(1'b1, 3'd2, 3'd1, 2'd2);
        step();
        addr_phase(1'b1, 3'd3, 3'd0, 2'd3);
        hwdata = 8'h5A;
        step();
        chk("pipe_pay1", payload, 16'h0D5A);
        addr_phase(1'b0, 3'd2, 3'd0, 2'd2);
        hwdata = 8'hA5;
        exp_q.push_back(8'h5A);
        step();
        chk("pipe_pay2", payload, 16'hA55A);
        chk_rd("pipe_rd_lo");
        addr_phase(1'b0, 3'd3, 3'd0, 2'd3);
        hwdata = 8'h00;
        exp_q.push_back(8'hA5);
        step();
        chk_rd("pipe_rd_hi");
        chk_resp("pipe", 1'b1, 1'b0);
        bus_idle();
        step();
        chk("pipe_rd_idle", {8'd0, hrdata}, 16'h0000);

        // Reset while a write data phase is held pending
        addr_phase(1'b1, 3'd4, 3'd0, 2'd2);
        step();
        bus_idle();
        hwdata = 8'h1A;
        hready = 1'b0;
        hreset_n = 1'b1;
        step();
        step();
        step();
        hreset_n = 1'b0;
        hready = 1'b1;
        step();
        chk("mrst_data_size", {11'd0, data_size}, 16'h0000);
        chk("mrst_payload", payload, 16'h0000);
        chk("mrst_hrdata", {8'd0, hrdata}, 16'h0000);
        chk_resp("mrst", 1'b1, 1'b0);

        if (exp_q.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL scoreboard_drain: got %0d left expected 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ahb_interface.md
# ahb_interface

AHB-Lite slave exposing a small byte-addressed register file on an 8-bit data bus. It holds a 16-bit payload register and a 5-bit data-size register, both written by the bus master and driven out to downstream logic. It also returns a 2-bit error status supplied by other logic as a read-only register. It sits between the system AHB fabric and a transmit/processing block that consumes `payload` and `data_size`.

## Interface
Parameters:
- ERR_STATUS_ADDRESS, 1: byte address of the read-only error-status register.
- PAYLOAD_ADDRESS, 2: byte address of payload[7:0]; payload[15:8] is at PAYLOAD_ADDRESS+1.
- DATA_SIZE_ADDRESS, 4: byte address of the data-size register.
- ERR_STATUS_HSIZE, 0: nominal hsize for the error-status register (byte).
- PAYLOAD_HSIZE, 1: nominal hsize for payload (halfword).
- DATA_SIZE_HSIZE, 0: nominal hsize for data_size (byte).

Ports:
- hclk  in  1  bus clock; all logic on the rising edge.
- hreset_n  in  1  reset. One clock; reset is synchronous and active-high (1 = reset, sampled on rising hclk).
- hsel_x  in  1  slave select.
- hready  in  1  bus ready; high completes the current data phase and qualifies address sampling.
- hwrite  in  1  1 = write, 0 = read.
- haddr  in  3  byte address.
- htrans  in  2  transfer type: 0 IDLE, 1 BUSY, 2 NONSEQ, 3 SEQ.
- hsize  in  3  transfer size.
- hwdata  in  8  write data, valid in the data phase.
- err_status  in  2  status from downstream logic.
- payload  out  16  payload register.
- data_size  out  5  data-size register.
- hrdata  out  8  read data.
- hready_out  out  1  slave ready.
- hresp  out  1  0 OKAY, 1 ERROR.

## Operation
- Address phase is accepted on a rising edge with hsel_x=1, hready=1 and htrans=NONSEQ or SEQ.
- On acceptance, register the following for the data phase: haddr, hwrite, hsize, and a valid flag.
- IDLE, BUSY, hsel_x=0 or hready=0 accept nothing. A registered data phase stays pending until the first edge with hready=1.
- Data phase completes on the first rising edge with hready=1 after acceptance. Writes use hwdata sampled at that edge:
  - DATA_SIZE_ADDRESS: data_size <= hwdata[4:0].
  - PAYLOAD_ADDRESS: payload[7:0] <= hwdata.
  - PAYLOAD_ADDRESS+1: payload[15:8] <= hwdata.
- Reads are combinational from the registered data-phase address while a read is pending; otherwise hrdata=0:
  - ERR_STATUS_ADDRESS: {6'b0, err_status}.
  - PAYLOAD_ADDRESS: payload[7:0].
  - PAYLOAD_ADDRESS+1: payload[15:8].
  - DATA_SIZE_ADDRESS: {3'b0, data_size}.
  - Any other address: 0.
- Only the addressed byte lane is ever written. Any hsize <= 1 is legal at any mapped address.
- Illegal transfers: unmapped address, hsize > 1, or a write to ERR_STATUS_ADDRESS. These change no register and produce the ERROR response.

## Timing
- Reset values: payload=0, data_size=0, hrdata=0, hready_out=1, hresp=0, pending data phase cleared.
- OKAY transfers have zero wait states: hready_out=1 and hresp=0.
- Write latency: the register updates at the same edge that completes the data phase.
- ERROR response runs for 2 cycles:
  - Cycle 1: hready_out=0, hresp=1.
  - Cycle 2: hready_out=1, hresp=1.
  - Then return to OKAY.
  - No new address phase is accepted during cycle 1.
- Back-to-back pipelining: a new address phase may be accepted at the same edge that completes the previous data phase.
- Reset asserted mid-transfer discards the pending phase; no write occurs.

## Configuration
- AHB_IF_ERROR_RESP_EN defined: illegal transfers produce the 2-cycle ERROR response described above.
- AHB_IF_ERROR_RESP_EN undefined:
  - hresp is tied to 0 and hready_out to 1.
  - Illegal writes are silently ignored.
  - Illegal reads return 0.

## Test plan
- Reset, then write 12 to DATA_SIZE_ADDRESS with hsize=0, with 1 address wait and hready low for 2 data cycles -> data_size=5'd12 only after hready rises; hresp=0 throughout.
- Write 0x29 to address 2 with hsize=1, then 0x0D to address 3 with hsize=0, pipelined with IDLE after -> payload=16'h0D29.
- Read DATA_SIZE_ADDRESS after the first write -> hrdata=8'h0C in the data phase, 0 otherwise. Read address 1 with err_status=2'b10 -> hrdata=8'h02.
- Write to address 1, address 6, or with hsize=2 (macro defined) -> no register change; hready_out low for 1 cycle; hresp high for 2 cycles.
- Accept a write to DATA_SIZE_ADDRESS, then assert hreset_n for 3 cycles before the data phase completes -> data_size=0, payload=0, hrdata=0, hready_out=1, hresp=0.
- Same illegal write with the macro undefined -> hresp stays 0, hready_out stays 1, registers unchanged.
